// File: rtl/breath_pwm_ctrl.sv
// Breathing-LED PWM generator: the duty ramps linearly up and down forever, and
// debounced key pulses select how many PWM periods each duty step is held.
module breath_pwm_ctrl #(
    parameter int PWM_W      = 8,
    parameter int SPEED_W    = 3,
    parameter int SPEED_MAX  = 7,
    parameter int SPEED_INIT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_up,
    input  logic               key_down,
    output logic               led,
    output logic [SPEED_W-1:0] speed_lvl
);

    localparam logic [PWM_W-1:0]   DUTY_MAX = '1;
    localparam logic [PWM_W-1:0]   DUTY_MIN = '0;
    localparam logic [SPEED_W-1:0] LVL_MAX  = SPEED_W'(SPEED_MAX);
    localparam logic [SPEED_W-1:0] LVL_INIT = SPEED_W'(SPEED_INIT);

    typedef enum logic {
        RISE = 1'b0,
        FALL = 1'b1
    } ramp_state_t;

    ramp_state_t        state;
    logic [PWM_W-1:0]   pwm_cnt;
    logic [PWM_W-1:0]   duty;
    logic [PWM_W-1:0]   duty_up;
    logic [PWM_W-1:0]   duty_dn;
    logic [SPEED_W-1:0] hold_cnt;
    logic [SPEED_W-1:0] lvl_nxt;
    logic               period_end;

    // Saturating level update; opposing pulses in the same cycle cancel.
    function automatic logic [SPEED_W-1:0] lvl_step(input logic [SPEED_W-1:0] lvl,
                                                    input logic               up,
                                                    input logic               dn);
        logic [SPEED_W-1:0] res;
        res = lvl;
        if (up && !dn && (lvl != LVL_MAX))
            res = lvl + 1'b1;
        else if (dn && !up && (lvl != '0))
            res = lvl - 1'b1;
        return res;
    endfunction

    always_comb begin
        lvl_nxt    = lvl_step(speed_lvl, key_up, key_down);
        period_end = (pwm_cnt == DUTY_MAX);
        duty_up    = duty + 1'b1;
        duty_dn    = duty - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led       <= 1'b0;
            speed_lvl <= LVL_INIT;
            pwm_cnt   <= '0;
            duty      <= '0;
            hold_cnt  <= LVL_MAX - LVL_INIT;
            state     <= RISE;
        end else begin
            pwm_cnt   <= pwm_cnt + 1'b1;
            led       <= (pwm_cnt < duty);
            speed_lvl <= lvl_nxt;
            if (period_end) begin
                if (hold_cnt != '0) begin
                    hold_cnt <= hold_cnt - 1'b1;
                end else begin
                    // Reload from the level registered now; a key pulse in
                    // this same cycle only affects the following reload.
                    hold_cnt <= LVL_MAX - speed_lvl;
                    case (state)
                        RISE: begin
                            duty <= duty_up;
                            if (duty_up == DUTY_MAX)
                                state <= FALL;
                        end
                        FALL: begin
                            duty <= duty_dn;
                            if (duty_dn == DUTY_MIN)
                                state <= RISE;
                        end
                        default: state <= RISE;
                    endcase
                end
            end
        end
    end

endmodule
